// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, ACK check and timeout on two open-drain lines.
// Ports:
//   i_clk, i_reset      system clock, async active-high reset
//   i_PS2Clk, i_PS2Data raw pad values (asynchronous, synchronised here)
//   i_data, i_start     command byte and 1-cycle request (IDLE only)
//   o_PS2Clk_oe         1 = pull PS/2 clock low
//   o_PS2Data_oe        1 = pull PS/2 data low
//   o_busy              high in every state except IDLE
//   o_done, o_error     end-of-transaction pulse; error = NACK or timeout
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 50
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_PS2Clk,
  input  logic       i_PS2Data,
  input  logic [7:0] i_data,
  input  logic       i_start,
  output logic       o_PS2Clk_oe,
  output logic       o_PS2Data_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam int IW =
    (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_WAITIDLE = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]    r_state;
  logic [9:0]    r_frame;
  logic [IW-1:0] r_icnt;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_bcnt;
  logic          r_clk_oe;
  logic          r_data_oe;
  logic          r_error;

  logic r_clk_s1;
  logic r_clk_s2;
  logic r_clk_prev;
  logic r_data_s1;
  logic r_data_s2;
  logic w_fall;

  // Idle lines are high, so the synchronisers reset to 1 to avoid
  // reporting a spurious falling edge after reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= i_PS2Clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= i_PS2Data;
      r_data_s2  <= r_data_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_icnt    <= '0;
      r_tcnt    <= '0;
      r_bcnt    <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_frame   <= {1'b1, ~^i_data, i_data};
            r_icnt    <= '0;
            r_error   <= 1'b0;
            r_clk_oe  <= 1'b1;
            r_data_oe <= 1'b0;
            r_state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_icnt == INH_LAST) begin
            r_data_oe <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            r_icnt <= r_icnt + 1'b1;
          end
        end
        S_REQ: begin
          // Start bit stays on data; device now owns the clock.
          r_clk_oe <= 1'b0;
          r_bcnt   <= '0;
          r_tcnt   <= '0;
          r_state  <= S_SEND;
        end
        S_SEND, S_ACK, S_WAITIDLE: begin
          // One budget covers the whole device-clocked phase.
          if (r_tcnt == TMO_LAST) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_error   <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_state == S_SEND) begin
              if (w_fall) begin
                r_data_oe <= ~r_frame[0];
                r_frame   <= {1'b0, r_frame[9:1]};
                r_bcnt    <= r_bcnt + 1'b1;
                if (r_bcnt == 4'd9) begin
                  r_state <= S_ACK;
                end
              end
            end else if (r_state == S_ACK) begin
              if (w_fall) begin
                r_error <= r_data_s2;
                r_state <= S_WAITIDLE;
              end
            end else begin
              if (r_clk_s2 && r_data_s2) begin
                r_state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_PS2Clk_oe  = r_clk_oe;
  assign o_PS2Data_oe = r_data_oe;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_error      = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device model.
// Ports driven through open-drain pad models shared with the device.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 3000;
  localparam int H   = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  logic clk_oe, data_oe, busy, done, err;
  logic pad_clk, pad_data;

  assign pad_clk  = ~(clk_oe | dev_clk_low);
  assign pad_data = ~(data_oe | dev_data_low);

  int tests = 0;
  int fails = 0;
  int low_cnt = 0;
  int req_cnt = 0;
  int done_cnt = 0;

  ps2_host_tx #(
    .CLK_FREQ_HZ   (100_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_PS2Clk    (pad_clk),
    .i_PS2Data   (pad_data),
    .i_data      (data),
    .i_start     (start),
    .o_PS2Clk_oe (clk_oe),
    .o_PS2Data_oe(data_oe),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clk_oe) low_cnt++;
    if (clk_oe && data_oe) req_cnt++;
    if (done) done_cnt++;
  end

  task automatic send_start(input logic [7:0] b);
    @(negedge clk);
    data  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = 8'hAA;
  endtask

  task automatic dev_pulse(output logic bit_v);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    bit_v = pad_data;
    repeat (H) @(negedge clk);
  endtask

  task automatic dev_txn(input logic ack,
                         output logic [9:0] bits,
                         output logic ok);
    int n;
    logic b;
    ok = 1'b1;
    bits = '0;
    n = 0;
    while (clk_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (clk_oe) ok = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_pulse(b);
      bits[i] = b;
    end
    if (ack) dev_data_low = 1'b1;
    repeat (H / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    if (ack) begin
      repeat (H / 2) @(negedge clk);
      dev_data_low = 1'b0;
    end
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!done) ok = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if (clk_oe !== 1'b0) begin
      fails++;
      $display("FAIL rst_clk_oe: got %b want 0", clk_oe);
    end
    tests++;
    if (data_oe !== 1'b0) begin
      fails++;
      $display("FAIL rst_data_oe: got %b want 0", data_oe);
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy_done: got %b%b want 00", busy, done);
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL rst_error: got %b want 0", err);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_f4;
    logic [9:0] bits;
    logic ok;
    int lb, rb;
    lb = low_cnt;
    rb = req_cnt;
    @(negedge clk);
    data  = 8'hF4;
    start = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (clk_oe !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL f4_accept: clk_oe=%b busy=%b want 11",
               clk_oe, busy);
    end
    @(negedge clk);
    start = 1'b0;
    data  = 8'h00;
    dev_txn(1'b1, bits, ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL f4_handshake: got %b want 1", ok);
    end
    tests++;
    if (bits !== 10'h2F4) begin
      fails++;
      $display("FAIL f4_bits: got %h want 2f4", bits);
    end
    tests++;
    if (low_cnt - lb !== INH + 1) begin
      fails++;
      $display("FAIL f4_clk_low: got %0d want %0d",
               low_cnt - lb, INH + 1);
    end
    tests++;
    if (req_cnt - rb !== 1) begin
      fails++;
      $display("FAIL f4_req: got %0d want 1", req_cnt - rb);
    end
    tests++;
    if (err !== 1'b0 || clk_oe !== 1'b0 || data_oe !== 1'b0) begin
      fails++;
      $display("FAIL f4_done: err=%b oe=%b%b want 000",
               err, clk_oe, data_oe);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits;
    logic ok;
    send_start(8'hFF);
    dev_txn(1'b1, bits, ok);
    tests++;
    if (!ok || bits !== 10'h3FF || err !== 1'b0) begin
      fails++;
      $display("FAIL ff_frame: bits=%h err=%b ok=%b want 3ff 0 1",
               bits, err, ok);
    end
    // Still in DONE here: this request must be dropped.
    data  = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || clk_oe !== 1'b0) begin
      fails++;
      $display("FAIL done_start_ignored: busy=%b clk_oe=%b want 00",
               busy, clk_oe);
    end
    send_start(8'h00);
    dev_txn(1'b1, bits, ok);
    tests++;
    if (!ok || bits !== 10'h300 || err !== 1'b0) begin
      fails++;
      $display("FAIL 00_frame: bits=%h err=%b ok=%b want 300 0 1",
               bits, err, ok);
    end
    @(negedge clk);
  endtask

  task automatic test_nack;
    logic [9:0] bits;
    logic ok;
    send_start(8'hF4);
    dev_txn(1'b0, bits, ok);
    tests++;
    if (!ok || err !== 1'b1) begin
      fails++;
      $display("FAIL nack_err: err=%b ok=%b want 1 1", err, ok);
    end
    tests++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b0) begin
      fails++;
      $display("FAIL nack_release: oe=%b%b want 00", clk_oe, data_oe);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    send_start(8'hF4);
    n = 0;
    while (clk_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b1) begin
      fails++;
      $display("FAIL to_release: oe=%b%b want 01", clk_oe, data_oe);
    end
    n = 0;
    while (!done && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== TMO || done !== 1'b1) begin
      fails++;
      $display("FAIL to_cycles: got %0d done=%b want %0d 1",
               n, done, TMO);
    end
    tests++;
    if (err !== 1'b1 || clk_oe !== 1'b0 || data_oe !== 1'b0) begin
      fails++;
      $display("FAIL to_state: err=%b oe=%b%b want 100",
               err, clk_oe, data_oe);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    logic [9:0] bits;
    logic ok;
    logic b;
    int n;
    send_start(8'hF4);
    n = 0;
    while (clk_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (H) @(negedge clk);
    for (int i = 0; i < 4; i++) dev_pulse(b);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (clk_oe !== 1'b0 || data_oe !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: oe=%b%b busy=%b want 000",
               clk_oe, data_oe, busy);
    end
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_start(8'hF4);
    dev_txn(1'b1, bits, ok);
    tests++;
    if (!ok || bits !== 10'h2F4 || err !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: bits=%h err=%b ok=%b want 2f4 0 1",
               bits, err, ok);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy_start;
    logic [9:0] bits;
    logic ok;
    int db;
    db = done_cnt;
    send_start(8'hF4);
    fork
      dev_txn(1'b1, bits, ok);
      begin
        repeat (300) @(negedge clk);
        data  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    tests++;
    if (!ok || bits !== 10'h2F4 || err !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_frame: bits=%h err=%b want 2f4 0",
               bits, err);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (done_cnt - db !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_done: dones=%0d busy=%b want 1 0",
               done_cnt - db, busy);
    end
  endtask

  initial begin
    test_reset;
    test_f4;
    test_back_to_back;
    test_nack;
    test_timeout;
    test_reset_midframe;
    test_ignore_busy_start;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xF4 "enable data reporting", 0xFF "reset") from the FPGA to the mouse. It sits beside the PS/2 frame receiver on the same two open-drain lines and drives them through top-level tri-states: pad is pulled to 0 when the `_oe` output is 1, released otherwise. It owns the full transaction: request-to-send, 8 data bits, parity, stop, ACK check and timeout. While a transaction is in progress, upstream logic masks the receiver using o_busy.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency; used only in derived defaults.
- INHIBIT_CYCLES, CLK_FREQ_HZ/10_000 (100 µs), clock-low hold time before the start bit.
- TIMEOUT_CYCLES, CLK_FREQ_HZ/50 (20 ms), maximum time from clock release to ACK/idle.

- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_PS2Clk  in  1  raw PS/2 clock pad value (asynchronous)
- i_PS2Data  in  1  raw PS/2 data pad value (asynchronous)
- i_data  in  8  command byte; sampled when i_start is accepted
- i_start  in  1  1-cycle request; accepted only in IDLE
- o_PS2Clk_oe  out  1  1 = pull PS/2 clock low
- o_PS2Data_oe  out  1  1 = pull PS/2 data low
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  1-cycle pulse at the end of a transaction
- o_error  out  1  valid with o_done: 1 = NACK or timeout

## Operation
- Input synchronisers: two flops on each PS/2 input. Falling edge = previous synced clock 1 and current synced clock 0. Edge detection runs continuously.
- Reset: all outputs 0. State goes to IDLE and all counters clear. Because reset is asynchronous, both lines are released immediately, including mid-frame.
- Frame shift register: {1'b1 stop, ~^data parity (odd), data[7:0]}, loaded on accept and shifted LSB first.
- States:
  - IDLE: outputs released. On i_start, latch the frame, clear the counter, go to INHIBIT. o_busy rises the next cycle.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: clk_oe=1 and data_oe=1 (start bit 0) for exactly 1 cycle, then go to SEND with clk_oe=0. Clear the bit count and the timeout counter.
  - SEND: on each falling edge, set data_oe = ~frame[0], shift, and increment the bit count.
    - Falling edges 1–8 carry d0..d7, edge 9 carries parity, edge 10 carries stop (data released).
    - After edge 10, go to ACK.
  - ACK: on the next falling edge (the 11th), sample synced data. 0 = ACK, 1 = NACK. Go to WAITIDLE.
  - WAITIDLE: wait until synced clock and synced data are both 1, then go to DONE.
  - DONE: o_done=1 and o_error=nack for 1 cycle, then go to IDLE.
- Timeout: a counter runs in SEND, ACK and WAITIDLE. When it reaches TIMEOUT_CYCLES-1, release both lines, set the error flag and go to DONE.
- i_start outside IDLE is ignored; i_data is not re-sampled.
- i_start in the same cycle as DONE is ignored (FSM is not yet in IDLE).
- Counter widths are $clog2 of their parameter. There is no wrap-around: counters clear on every state entry.

## Timing
- Accept to clock pulled low: 1 cycle (registered outputs).
- Clock low duration: INHIBIT_CYCLES + 1 cycles, with data pulled low during the final cycle.
- Data update on a falling edge: 3 cycles after the pad edge (2 sync flops + 1 output register). This is well inside the device's ≥5 µs clock-low phase.
- o_done: one cycle, 1 cycle after line-idle detection or timeout.
- o_error: held at its final value until the next accept, so it is stable throughout the o_done cycle.
- Back-to-back: a new i_start is accepted no earlier than the cycle after o_done.

## Test plan
- Send 0xF4 through a behavioural device model (≈12.5 kHz clock, ACK driven): data bits on rising edges read 0,0,1,0,1,1,1,1, parity 0, stop 1. Expect o_done with o_error=0, and clock held low ≥100 µs beforehand.
- Send 0xFF: parity bit 1. Send 0x00: parity bit 1. In both cases o_error=0.
- Device NACKs (data left high on the 11th falling edge): expect o_done with o_error=1 and both `_oe` outputs at 0.
- Device never clocks after release: expect o_done with o_error=1 exactly TIMEOUT_CYCLES cycles after REQ exits, and both lines released.
- Assert i_reset after the 5th falling edge: the same cycle, o_PS2Clk_oe=o_PS2Data_oe=o_busy=0. A subsequent 0xF4 send completes correctly.
- Pulse i_start with 0x55 while busy sending 0xF4: ignored, and the frame on the wire remains 0xF4. A single o_done is produced.
